// File: rtl/thd_pkg.sv
// Shared types and sizing helpers for the sequential THD engine.
package thd_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SQRT_H = 3'd1,
        SQRT_F = 3'd2,
        DIV    = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int FLAG_FZERO = 0;
    localparam int FLAG_SAT   = 1;
    localparam int FLAG_OVF   = 2;

    // Accumulator width: two full squares plus headroom for MAXH adds, kept even for the sqrt.
    function automatic int calc_aw(input int w, input int maxh);
        int aw;
        aw = 2 * w + $clog2(maxh + 1);
        if (aw % 2 != 0) begin
            aw = aw + 1;
        end else begin
            aw = aw;
        end
        return aw;
    endfunction

    function automatic int calc_rw(input int w, input int maxh);
        return calc_aw(w, maxh) / 2;
    endfunction

    function automatic int calc_qw(input int w, input int maxh, input int frac);
        return calc_rw(w, maxh) + frac;
    endfunction

endpackage

// File: rtl/thd_calc_seq_isqrt_iter.sv
// Restoring integer square root, one root bit per cycle; the first bit is resolved
// on the start cycle straight from the radicand input.
module isqrt_iter #(
    parameter int AW = 52,
    parameter int RW = 26
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] radicand,
    output logic          busy,
    output logic          done,
    output logic [RW-1:0] root
);

    localparam int CW = $clog2(RW + 1);

    logic [AW-1:0] rad_r;
    logic [RW+1:0] rem_r;
    logic [CW-1:0] cnt_r;

    logic [AW-1:0] rad_src_s;
    logic [RW+1:0] rem_src_s;
    logic [RW-1:0] root_src_s;
    logic [RW+1:0] rem_t_s;
    logic [RW+1:0] trial_s;
    logic          ge_s;
    logic [RW+1:0] rem_n_s;
    logic [RW-1:0] root_n_s;

    // One restoring step: bring down two radicand bits, try subtracting 4*root+1.
    always_comb begin
        rad_src_s  = rad_r;
        rem_src_s  = rem_r;
        root_src_s = root;
        if (start) begin
            rad_src_s  = radicand;
            rem_src_s  = '0;
            root_src_s = '0;
        end else begin
            rad_src_s  = rad_r;
            rem_src_s  = rem_r;
            root_src_s = root;
        end
        rem_t_s  = (rem_src_s << 2) | (RW + 2)'(rad_src_s[AW-1 -: 2]);
        trial_s  = {root_src_s, 2'b01};
        ge_s     = (rem_t_s >= trial_s);
        if (ge_s) begin
            rem_n_s = rem_t_s - trial_s;
        end else begin
            rem_n_s = rem_t_s;
        end
        root_n_s = (root_src_s << 1) | RW'(ge_s);
    end

    // Iteration state: start performs step 1, busy covers the remaining RW-1 steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rad_r <= '0;
            rem_r <= '0;
            root  <= '0;
            cnt_r <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (start) begin
            rad_r <= rad_src_s << 2;
            rem_r <= rem_n_s;
            root  <= root_n_s;
            cnt_r <= CW'(RW - 1);
            busy  <= (RW > 1);
            done  <= (RW == 1);
        end else if (busy) begin
            rad_r <= rad_src_s << 2;
            rem_r <= rem_n_s;
            root  <= root_n_s;
            cnt_r <= cnt_r - CW'(1);
            if (cnt_r == CW'(1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/thd_calc_seq.sv
// Sequential THD engine: accumulates |F|^2 and sum|Hk|^2 from a bin stream, then
// computes floor((sqrt(H) << FRAC) / sqrt(F)) with a shared sqrt and an inline divider.
module thd_calc_seq
    import thd_pkg::*;
#(
    parameter int W    = 24,
    parameter int MAXH = 15,
    parameter int FRAC = 16,
    parameter int OW   = 24
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [W-1:0]            in_re,
    input  logic signed [W-1:0]            in_im,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OW-1:0]                  thd,
    output logic [$clog2(MAXH+1)-1:0]      nharm,
    output logic [2:0]                     flags
);

    localparam int AW  = calc_aw(W, MAXH);
    localparam int RW  = calc_rw(W, MAXH);
    localparam int QW  = calc_qw(W, MAXH, FRAC);
    localparam int NHW = $clog2(MAXH + 1);
    localparam int PW  = $clog2(QW + 1);

    state_t         state_r;
    logic [PW-1:0]  phase_r;
    logic           first_r;
    logic [AW-1:0]  f_r;
    logic [AW-1:0]  h_r;
    logic [NHW-1:0] nhcnt_r;
    logic           ovf_r;
    logic [RW-1:0]  sh_r;
    logic [QW-1:0]  q_r;
    logic [RW-1:0]  drem_r;

    logic signed [2*W-1:0] re2_s;
    logic signed [2*W-1:0] im2_s;
    logic [AW-1:0]         sq_s;

    logic          sqrt_start_s;
    logic [AW-1:0] sqrt_rad_s;
    logic          sqrt_busy_s;
    logic          sqrt_done_s;
    logic [RW-1:0] sqrt_root_s;

    logic [QW-1:0] q_src_s;
    logic [RW-1:0] drem_src_s;
    logic [RW:0]   rem_t_s;
    logic          ge_s;
    logic [RW-1:0] drem_n_s;
    logic [QW-1:0] q_n_s;
    logic [OW-1:0] fin_thd_s;
    logic [2:0]    fin_flags_s;

    // Squares are formed at 2W so the most negative component squares without wrapping.
    assign re2_s = (2 * W)'(in_re) * (2 * W)'(in_re);
    assign im2_s = (2 * W)'(in_im) * (2 * W)'(in_im);
    assign sq_s  = AW'($unsigned(re2_s)) + AW'($unsigned(im2_s));

    // Sqrt unit is time-shared: H during SQRT_H, F during SQRT_F.
    always_comb begin
        sqrt_start_s = 1'b0;
        sqrt_rad_s   = h_r;
        if ((state_r == SQRT_H || state_r == SQRT_F) && phase_r == '0 && !sqrt_busy_s) begin
            sqrt_start_s = 1'b1;
        end else begin
            sqrt_start_s = 1'b0;
        end
        if (state_r == SQRT_F) begin
            sqrt_rad_s = f_r;
        end else begin
            sqrt_rad_s = h_r;
        end
    end

    isqrt_iter #(
        .AW(AW),
        .RW(RW)
    ) u_isqrt (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (sqrt_start_s),
        .radicand (sqrt_rad_s),
        .busy     (sqrt_busy_s),
        .done     (sqrt_done_s),
        .root     (sqrt_root_s)
    );

    // Restoring divide step; sF stays on the sqrt root output for the whole DIV phase.
    always_comb begin
        q_src_s    = q_r;
        drem_src_s = drem_r;
        if (phase_r == '0) begin
            q_src_s    = {sh_r, {FRAC{1'b0}}};
            drem_src_s = '0;
        end else begin
            q_src_s    = q_r;
            drem_src_s = drem_r;
        end
        rem_t_s = {drem_src_s, q_src_s[QW-1]};
        ge_s    = (rem_t_s >= {1'b0, sqrt_root_s});
        if (ge_s) begin
            drem_n_s = RW'(rem_t_s - {1'b0, sqrt_root_s});
        end else begin
            drem_n_s = RW'(rem_t_s);
        end
        q_n_s = {q_src_s[QW-2:0], ge_s};
    end

    // Result shaping: zero fundamental wins over saturation.
    always_comb begin
        fin_thd_s   = '0;
        fin_flags_s = 3'b000;
        if (sqrt_root_s == '0) begin
            fin_thd_s               = '1;
            fin_flags_s[FLAG_FZERO] = 1'b1;
        end else if ((q_r >> OW) != '0) begin
            fin_thd_s             = '1;
            fin_flags_s[FLAG_SAT] = 1'b1;
        end else begin
            fin_thd_s = OW'(q_r);
        end
        fin_flags_s[FLAG_OVF] = ovf_r;
    end

    // Frame FSM: accumulate, sqrt H, sqrt F, divide (+1 finalize cycle), hold result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            phase_r   <= '0;
            first_r   <= 1'b1;
            f_r       <= '0;
            h_r       <= '0;
            nhcnt_r   <= '0;
            ovf_r     <= 1'b0;
            sh_r      <= '0;
            q_r       <= '0;
            drem_r    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            thd       <= '0;
            nharm     <= '0;
            flags     <= 3'b000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        if (first_r) begin
                            f_r     <= sq_s;
                            first_r <= 1'b0;
                        end else if (nhcnt_r < NHW'(MAXH)) begin
                            h_r     <= h_r + sq_s;
                            nhcnt_r <= nhcnt_r + NHW'(1);
                        end else begin
                            ovf_r <= 1'b1;
                        end
                        if (in_last) begin
                            state_r  <= SQRT_H;
                            phase_r  <= '0;
                            in_ready <= 1'b0;
                        end
                    end
                end
                SQRT_H: begin
                    if (phase_r == PW'(RW - 1)) begin
                        state_r <= SQRT_F;
                        phase_r <= '0;
                    end else begin
                        phase_r <= phase_r + PW'(1);
                    end
                end
                SQRT_F: begin
                    if (phase_r == '0 && sqrt_done_s) begin
                        sh_r <= sqrt_root_s;
                    end
                    if (phase_r == PW'(RW - 1)) begin
                        state_r <= DIV;
                        phase_r <= '0;
                    end else begin
                        phase_r <= phase_r + PW'(1);
                    end
                end
                DIV: begin
                    if (phase_r == PW'(QW)) begin
                        state_r   <= DONE;
                        phase_r   <= '0;
                        out_valid <= 1'b1;
                        thd       <= fin_thd_s;
                        nharm     <= nhcnt_r;
                        flags     <= fin_flags_s;
                    end else begin
                        if (sqrt_root_s != '0) begin
                            q_r    <= q_n_s;
                            drem_r <= drem_n_s;
                        end
                        phase_r <= phase_r + PW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r   <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        first_r   <= 1'b1;
                        f_r       <= '0;
                        h_r       <= '0;
                        nhcnt_r   <= '0;
                        ovf_r     <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    phase_r   <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_thd_calc_seq.sv
// Self-checking bench for thd_calc_seq: directed spec cases plus random frames
// checked against an arithmetic THD model.
module tb_thd_calc_seq;

    logic clk = 1'b0;
    logic rst_n;

    // Clock generation, 10 ns period.
    always #5 clk = ~clk;

    logic               in_valid, in_ready, in_last, out_valid, out_ready;
    logic signed [23:0] in_re, in_im;
    logic [23:0]        thd;
    logic [3:0]         nharm;
    logic [2:0]         flags;

    logic               v2, rdy2, last2, ov2, or2;
    logic signed [23:0] re2, im2;
    logic [23:0]        thd2;
    logic [1:0]         nh2;
    logic [2:0]         fl2;

    thd_calc_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .thd(thd), .nharm(nharm), .flags(flags)
    );

    thd_calc_seq #(.MAXH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2),
        .in_re(re2), .in_im(im2), .in_last(last2), .out_valid(ov2),
        .out_ready(or2), .thd(thd2), .nharm(nh2), .flags(fl2)
    );

    int          checks, errors;
    int          fr_re [0:31];
    int          fr_im [0:31];
    int          fr_n;
    logic [23:0] e_thd;
    int          e_nh;
    logic [2:0]  e_fl;
    int          lat;

    function automatic longint isqrt_ref(input longint x);
        longint s;
        s = longint'($floor($sqrt(real'(x))));
        while (s * s > x) s = s - 1;
        while ((s + 1) * (s + 1) <= x) s = s + 1;
        return s;
    endfunction

    // THD from the frame definition: F from beat 0, first maxh harmonics summed.
    task automatic model(input int maxh);
        longint f, h, sf, sh, q;
        int     nh;
        logic   ovf;
        f = longint'(fr_re[0]) * longint'(fr_re[0]) + longint'(fr_im[0]) * longint'(fr_im[0]);
        h = 0; nh = 0; ovf = 1'b0;
        for (int i = 1; i < fr_n; i++) begin
            if (nh < maxh) begin
                h  = h + longint'(fr_re[i]) * longint'(fr_re[i]) + longint'(fr_im[i]) * longint'(fr_im[i]);
                nh = nh + 1;
            end else begin
                ovf = 1'b1;
            end
        end
        sf = isqrt_ref(f);
        sh = isqrt_ref(h);
        e_fl = {ovf, 2'b00};
        e_nh = nh;
        if (sf == 0) begin
            e_thd = 24'hFFFFFF;
            e_fl[0] = 1'b1;
        end else begin
            q = (sh <<< 16) / sf;
            if (q >= (64'sd1 <<< 24)) begin
                e_thd = 24'hFFFFFF;
                e_fl[1] = 1'b1;
            end else begin
                e_thd = 24'(q);
            end
        end
    endtask

    task automatic send_frame();
        int t;
        for (int i = 0; i < fr_n; i++) begin
            t = 0;
            while (in_ready !== 1'b1 && t < 200) begin
                @(posedge clk); #1;
                t++;
            end
            checks++;
            if (t >= 200) begin
                errors++;
                $display("FAIL send_ready: in_ready=%b after %0d cycles, required 1", in_ready, t);
            end
            in_valid = 1'b1;
            in_re    = 24'(fr_re[i]);
            in_im    = 24'(fr_im[i]);
            in_last  = (i == fr_n - 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result(output int l);
        l = 0;
        while (out_valid !== 1'b1 && l < 300) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic finish_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic check_result(input string name);
        model(15);
        checks++;
        if (lat !== 95) begin errors++; $display("FAIL %s_latency: got %0d, required 95", name, lat); end
        checks++;
        if (thd !== e_thd) begin errors++; $display("FAIL %s_thd: got %0d, required %0d", name, thd, e_thd); end
        checks++;
        if (nharm !== 4'(e_nh)) begin errors++; $display("FAIL %s_nharm: got %0d, required %0d", name, nharm, e_nh); end
        checks++;
        if (flags !== e_fl) begin errors++; $display("FAIL %s_flags: got %b, required %b", name, flags, e_fl); end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || thd !== 24'd0 || nharm !== 4'd0 || flags !== 3'b000) begin
            errors++;
            $display("FAIL reset_state: rdy=%b ov=%b thd=%0d nh=%0d fl=%b, required 1 0 0 0 000",
                     in_ready, out_valid, thd, nharm, flags);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || rdy2 !== 1'b1 || ov2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy=%b ov=%b rdy2=%b ov2=%b, required 1 0 1 0", in_ready, out_valid, rdy2, ov2);
        end
    endtask

    task automatic test_basic();
        fr_n = 3;
        fr_re[0] = 3; fr_im[0] = 4;
        fr_re[1] = 0; fr_im[1] = 1;
        fr_re[2] = 0; fr_im[2] = 0;
        send_frame();
        wait_result(lat);
        check_result("basic");
        checks++;
        if (thd !== 24'd13107) begin errors++; $display("FAIL basic_const: got %0d, required 13107", thd); end
        finish_result();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_handshake: ov=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_precision();
        fr_n = 2;
        fr_re[0] = 1000; fr_im[0] = 0;
        fr_re[1] = 30;   fr_im[1] = 40;
        send_frame();
        wait_result(lat);
        check_result("precision");
        checks++;
        if (thd !== 24'd3276) begin errors++; $display("FAIL precision_const: got %0d, required 3276", thd); end
        finish_result();
    endtask

    task automatic test_fzero();
        fr_n = 2;
        fr_re[0] = 0; fr_im[0] = 0;
        fr_re[1] = 5; fr_im[1] = 0;
        send_frame();
        wait_result(lat);
        check_result("fzero");
        checks++;
        if (thd !== 24'hFFFFFF || flags !== 3'b001) begin
            errors++;
            $display("FAIL fzero_const: thd=%h fl=%b, required ffffff 001", thd, flags);
        end
        finish_result();
        fr_n = 1;
        fr_re[0] = 7; fr_im[0] = 0;
        send_frame();
        wait_result(lat);
        check_result("fund_only");
        checks++;
        if (thd !== 24'd0 || nharm !== 4'd0) begin
            errors++;
            $display("FAIL fund_only_const: thd=%0d nh=%0d, required 0 0", thd, nharm);
        end
        finish_result();
    endtask

    task automatic test_overflow();
        fr_n = 5;
        fr_re[0] = 1; fr_im[0] = 0;
        for (int i = 1; i < 5; i++) begin
            fr_re[i] = -8388608;
            fr_im[i] = 0;
        end
        model(2);
        for (int i = 0; i < fr_n; i++) begin
            checks++;
            if (rdy2 !== 1'b1) begin errors++; $display("FAIL ovf_accept%0d: rdy2=%b, required 1", i, rdy2); end
            v2    = 1'b1;
            re2   = 24'(fr_re[i]);
            im2   = 24'(fr_im[i]);
            last2 = (i == fr_n - 1);
            @(posedge clk); #1;
        end
        v2 = 1'b0; last2 = 1'b0;
        lat = 0;
        while (ov2 !== 1'b1 && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 92) begin errors++; $display("FAIL ovf_latency: got %0d, required 92", lat); end
        checks++;
        if (thd2 !== e_thd || thd2 !== 24'hFFFFFF) begin errors++; $display("FAIL ovf_thd: got %h, required %h", thd2, e_thd); end
        checks++;
        if (nh2 !== 2'(e_nh) || nh2 !== 2'd2) begin errors++; $display("FAIL ovf_nharm: got %0d, required %0d", nh2, e_nh); end
        checks++;
        if (fl2 !== e_fl || fl2 !== 3'b110) begin errors++; $display("FAIL ovf_flags: got %b, required %b", fl2, e_fl); end
        or2 = 1'b1;
        @(posedge clk); #1;
        or2 = 1'b0;
    endtask

    task automatic random_frame();
        int famp, hamp;
        fr_n = int'($urandom_range(18, 1));
        famp = 1 << $urandom_range(22, 8);
        fr_re[0] = int'($urandom_range(2 * famp, 0)) - famp;
        fr_im[0] = int'($urandom_range(2 * famp, 0)) - famp;
        for (int i = 1; i < fr_n; i++) begin
            hamp = 1 << $urandom_range(16, 0);
            fr_re[i] = int'($urandom_range(2 * hamp, 0)) - hamp;
            fr_im[i] = int'($urandom_range(2 * hamp, 0)) - hamp;
        end
    endtask

    task automatic test_backpressure();
        random_frame();
        send_frame();
        wait_result(lat);
        check_result("bp");
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || thd !== e_thd || nharm !== 4'(e_nh) || flags !== e_fl || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: ov=%b thd=%0d nh=%0d fl=%b rdy=%b, required 1 %0d %0d %b 0",
                         c, out_valid, thd, nharm, flags, in_ready, e_thd, e_nh, e_fl);
            end
        end
        finish_result();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: ov=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
        fr_n = 2;
        fr_re[0] = 1000; fr_im[0] = 0;
        fr_re[1] = 30;   fr_im[1] = 40;
        send_frame();
        wait_result(lat);
        check_result("bp_next");
        finish_result();
    endtask

    task automatic test_reset_midcompute();
        int l;
        fr_n = 2;
        fr_re[0] = 3; fr_im[0] = 4;
        fr_re[1] = 0; fr_im[1] = 1;
        send_frame();
        repeat (40) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || thd !== 24'd0 || nharm !== 4'd0 || flags !== 3'b000) begin
            errors++;
            $display("FAIL midreset_state: rdy=%b ov=%b thd=%0d nh=%0d fl=%b, required 1 0 0 0 000",
                     in_ready, out_valid, thd, nharm, flags);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        l = 0;
        for (int c = 0; c < 110; c++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) l++;
        end
        checks++;
        if (l !== 0) begin errors++; $display("FAIL midreset_abort: out_valid high %0d cycles, required 0", l); end
        send_frame();
        wait_result(lat);
        check_result("midreset_fresh");
        checks++;
        if (thd !== 24'd13107) begin errors++; $display("FAIL midreset_const: got %0d, required 13107", thd); end
        finish_result();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 12; k++) begin
            random_frame();
            send_frame();
            wait_result(lat);
            check_result("random");
            finish_result();
        end
    endtask

    // Test sequence.
    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; in_re = '0; in_im = '0; in_last = 1'b0; out_ready = 1'b0;
        v2 = 1'b0; re2 = '0; im2 = '0; last2 = 1'b0; or2 = 1'b0;
        test_reset();
        test_basic();
        test_precision();
        test_fzero();
        test_overflow();
        test_backpressure();
        test_reset_midcompute();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
